// File: rtl/d8_fetch_seq_if.sv
// d8_fetch_seq_if: bus bundle between the fetch sequencer, the PC counter,
// instruction memory and decode. "master" is the sequencer side.
interface d8_fetch_seq_if #(
  parameter int IW = 32
);
  logic          start;
  logic          halt;
  logic [7:0]    pc_in;
  logic          pc_load;
  logic          pc_dir;
  logic [7:0]    pc_din;
  logic          imem_req;
  logic [7:0]    imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr_data;
  logic [7:0]    instr_pc;
  logic          br_req;
  logic [1:0]    br_type;
  logic [7:0]    br_target;
  logic          br_ack;
  logic          busy;
  logic          err;

  modport master (
    input  start, halt, pc_in, imem_ack, imem_data, instr_ready,
           br_req, br_type, br_target,
    output pc_load, pc_dir, pc_din, imem_req, imem_addr, instr_valid,
           instr_data, instr_pc, br_ack, busy, err
  );

  modport slave (
    output start, halt, pc_in, imem_ack, imem_data, instr_ready,
           br_req, br_type, br_target,
    input  pc_load, pc_dir, pc_din, imem_req, imem_addr, instr_valid,
           instr_data, instr_pc, br_ack, busy, err
  );
endinterface

// File: rtl/d8_fetch_seq.sv
// d8_fetch_seq: fetch sequencer for the dumb8 8-bit program counter.
// Drives the free-running +4 counter (load to hold), fetches from imem,
// presents instructions to decode and applies jump/relative/call/return.
// Build option: define D8_FETCH_CALL_STACK_EN to enable the return-address
// stack; without it a call acts as a plain jump and any return is a fault.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | out of reset, waiting for start
// S_LOAD   | counter settling after a load or a +4 step
// S_FETCH  | imem read outstanding at pc_in
// S_ISSUE  | instruction offered to decode, redirects accepted here
// S_HALTED | stopped on an instruction boundary, waiting for start
// S_ERR    | return-stack underflow, left only by reset
module d8_fetch_seq #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter int         IW           = 32,
  parameter int         RAS_DEPTH    = 4
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  d8_fetch_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FETCH  = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALTED = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] instr_data_q;
  logic [7:0]    instr_pc_q;
  logic          err_q;

  logic          pc_load;
  logic [7:0]    pc_din;
  logic          br_ack;
  logic          capture;
  logic          err_set;

`ifdef D8_FETCH_CALL_STACK_EN
  localparam int SPW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [7:0]     ras_q [RAS_DEPTH];
  logic [SPW-1:0] ras_sp_q;
  logic [SPW:0]   ras_cnt_q;
  logic [SPW-1:0] ras_top_idx;
  logic [7:0]     ras_top;
  logic           ras_push;
  logic           ras_pop;

  // sp points at the next free slot, so the newest entry sits one below it
  assign ras_top_idx = ras_sp_q - SPW'(1);
  assign ras_top     = ras_q[ras_top_idx];
`else
  logic unused_ras;
  assign unused_ras = (RAS_DEPTH != 0);
`endif

  // Next-state and counter control; the counter steps unless loaded, so
  // every cycle that must not move the PC reloads pc_in.
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_din  = 8'h00;
    br_ack  = 1'b0;
    capture = 1'b0;
    err_set = 1'b0;
`ifdef D8_FETCH_CALL_STACK_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_load = 1'b1;
          pc_din  = RESET_VECTOR;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        pc_load = 1'b1;
        pc_din  = bus.pc_in;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        pc_load = 1'b1;
        pc_din  = bus.pc_in;
        if (bus.imem_ack) begin
          capture = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pc_load = 1'b1;
        pc_din  = bus.pc_in;
        if (bus.br_req) begin
          br_ack  = 1'b1;
          state_d = S_LOAD;
          case (bus.br_type)
            2'b00: pc_din = bus.br_target;
            2'b01: pc_din = bus.pc_in + bus.br_target;
            2'b10: begin
              pc_din = bus.br_target;
`ifdef D8_FETCH_CALL_STACK_EN
              ras_push = 1'b1;
`endif
            end
            default: begin
`ifdef D8_FETCH_CALL_STACK_EN
              if (ras_cnt_q == '0) begin
                err_set = 1'b1;
                state_d = S_ERR;
              end else begin
                pc_din  = ras_top;
                ras_pop = 1'b1;
              end
`else
              err_set = 1'b1;
              state_d = S_ERR;
`endif
            end
          endcase
        end else if (bus.instr_ready) begin
          if (bus.halt) begin
            state_d = S_HALTED;
          end else begin
            pc_load = 1'b0;
            state_d = S_LOAD;
          end
        end
      end
      S_HALTED: begin
        // The halting instruction was already consumed, so resume by
        // stepping past it; the counter value is ready for FETCH next cycle.
        if (bus.start) begin
          pc_load = 1'b0;
          pc_din  = bus.pc_in;
          state_d = S_FETCH;
        end else begin
          pc_load = 1'b1;
          pc_din  = bus.pc_in;
        end
      end
      S_ERR: begin
        pc_load = 1'b1;
        pc_din  = bus.pc_in;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, captured instruction and sticky fault flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      instr_data_q <= '0;
      instr_pc_q   <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        instr_data_q <= bus.imem_data;
        instr_pc_q   <= bus.pc_in;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef D8_FETCH_CALL_STACK_EN
  // Stack pointer and fill count; a push on a full stack wraps and
  // overwrites the oldest entry while the count stays saturated.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ras_sp_q  <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push) begin
      ras_sp_q <= ras_sp_q + SPW'(1);
      if (ras_cnt_q != (SPW+1)'(RAS_DEPTH)) begin
        ras_cnt_q <= ras_cnt_q + (SPW+1)'(1);
      end
    end else if (ras_pop) begin
      ras_sp_q  <= ras_sp_q - SPW'(1);
      ras_cnt_q <= ras_cnt_q - (SPW+1)'(1);
    end
  end

  // Return-address storage; contents need no reset since count gates use.
  always_ff @(posedge sys_clk) begin
    if (ras_push) begin
      ras_q[ras_sp_q] <= bus.pc_in + 8'd4;
    end
  end
`endif

  assign bus.pc_load     = pc_load;
  assign bus.pc_dir      = 1'b1;
  assign bus.pc_din      = pc_din;
  assign bus.imem_req    = (state_q == S_FETCH);
  assign bus.imem_addr   = (state_q == S_FETCH) ? bus.pc_in : 8'h00;
  assign bus.instr_valid = (state_q == S_ISSUE);
  assign bus.instr_data  = instr_data_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.br_ack      = br_ack;
  assign bus.busy        = (state_q == S_LOAD) || (state_q == S_FETCH) ||
                           (state_q == S_ISSUE);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_d8_fetch_seq.sv
// tb_d8_fetch_seq: directed bench for d8_fetch_seq with a bench-side PC
// counter, an imem responder and a program-order model of the fetch stream.
module tb_d8_fetch_seq;
  localparam logic [7:0] RV    = 8'h00;
  localparam int         RAS_D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] pc_ctr;
  logic       inject_ack = 1'b0;
  int         ack_delay  = 1;

  logic [7:0] m_pc  = RV;
  logic       m_err = 1'b0;
  logic [7:0] m_ras[$];
  logic [7:0] issued[$];
  int         br_cnt = 0;

  d8_fetch_seq_if #(.IW(32)) bus ();

  d8_fetch_seq #(
    .RESET_VECTOR(RV),
    .IW(32),
    .RAS_DEPTH(RAS_D)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  assign bus.pc_in = pc_ctr;

  // The external program counter: synchronous load, otherwise +/-4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc_ctr <= 8'h00;
    else if (bus.pc_load)  pc_ctr <= bus.pc_din;
    else if (bus.pc_dir)   pc_ctr <= pc_ctr + 8'd4;
    else                   pc_ctr <= pc_ctr - 8'd4;
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a, ~a, 8'hC3, a ^ 8'h5A};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // imem responder: ack ack_delay cycles after the request is first seen.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    forever begin
      @(posedge clk); #1;
      if (inject_ack) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'hDEAD_BEEF;
      end else if (bus.imem_ack) begin
        bus.imem_ack = 1'b0;
      end else if (bus.imem_req) begin
        if (wcnt >= ack_delay) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = mem_word(bus.imem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Program-order model: m_pc is the address of the next instruction that
  // must be fetched and offered; it advances on consume and on redirect.
  initial begin
    logic [7:0] nxt;
    logic       fault;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pc  = RV;
        m_err = 1'b0;
        m_ras.delete();
      end else begin
        chk("pc_dir", bus.pc_dir, 1);
        chk("err_flag", bus.err, m_err);
        chk("br_ack", bus.br_ack, bus.instr_valid & bus.br_req);
        if (bus.imem_req) begin
          chk("fetch_addr", bus.imem_addr, m_pc);
          chk("fetch_hold", {bus.pc_load, bus.pc_din}, {1'b1, bus.pc_in});
        end
        if (bus.instr_valid) begin
          chk("instr_pc", bus.instr_pc, m_pc);
          chk("instr_data", bus.instr_data, mem_word(m_pc));
          if (bus.br_req) begin
            fault = 1'b0;
            nxt   = m_pc;
            case (bus.br_type)
              2'b00: nxt = bus.br_target;
              2'b01: nxt = m_pc + bus.br_target;
              2'b10: begin
                nxt = bus.br_target;
`ifdef D8_FETCH_CALL_STACK_EN
                m_ras.push_back(m_pc + 8'd4);
                if (m_ras.size() > RAS_D) void'(m_ras.pop_front());
`endif
              end
              default: begin
`ifdef D8_FETCH_CALL_STACK_EN
                if (m_ras.size() == 0) fault = 1'b1;
                else nxt = m_ras.pop_back();
`else
                fault = 1'b1;
`endif
              end
            endcase
            if (fault) begin
              m_err = 1'b1;
            end else begin
              chk("redirect_din", {bus.pc_load, bus.pc_din}, {1'b1, nxt});
              m_pc = nxt;
            end
            br_cnt++;
          end else if (bus.instr_ready) begin
            if (bus.halt) chk("halt_hold", {bus.pc_load, bus.pc_din}, {1'b1, bus.pc_in});
            else          chk("step_noload", bus.pc_load, 0);
            issued.push_back(m_pc);
            m_pc = m_pc + 8'd4;
          end else begin
            chk("stall_hold", {bus.pc_load, bus.pc_din}, {1'b1, bus.pc_in});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    bus.start = 1'b0; bus.halt = 1'b0; bus.instr_ready = 1'b0; bus.br_req = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_valid_pc(input logic [7:0] pc, input int budget, input string nm);
    int n;
    n = 0;
    while (!(bus.instr_valid && bus.instr_pc == pc) && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, {bus.instr_valid, bus.instr_pc}, {1'b1, pc});
  endtask

  task automatic wait_req(input int budget, input string nm);
    int n;
    n = 0;
    while (!bus.imem_req && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, bus.imem_req, 1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, bus.busy, 0);
  endtask

  // Issue a redirect in ISSUE; br_ack must be a single-cycle pulse.
  task automatic do_br(input logic [1:0] t, input logic [7:0] tgt);
    bus.br_req = 1'b1; bus.br_type = t; bus.br_target = tgt;
    #1;
    chk("br_ack_high", bus.br_ack, 1);
    @(posedge clk); #1;
    bus.br_req = 1'b0;
    chk("br_ack_low", bus.br_ack, 0);
  endtask

  initial begin
    int br_base;
    int base;
    logic [7:0] targets [5];
    logic [7:0] rets [4];
    bus.start = 1'b0; bus.halt = 1'b0; bus.instr_ready = 1'b0;
    bus.br_req = 1'b0; bus.br_type = 2'b00; bus.br_target = 8'h00;

    // Reset values
    rst_n = 1'b0;
    step(2);
    chk("rst_ctrl", {bus.busy, bus.err, bus.instr_valid, bus.imem_req, bus.pc_load, bus.br_ack}, 0);
    chk("rst_instr_data", bus.instr_data, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_addr_din", {bus.imem_addr, bus.pc_din}, 0);
    rst_n = 1'b1;
    step(1);

    // Sequential fetch 00,04,08,0C with decode always ready
    bus.instr_ready = 1'b1;
    pulse_start();
    wait_valid_pc(8'h10, 60, "seq_reach_10");
    bus.instr_ready = 1'b0;
    chk("seq_count", issued.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("seq_pc%0d", i), (i < issued.size()) ? issued[i] : 8'hEE, 8'(4 * i));

    // Five stall cycles at 10
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_pc_in", bus.pc_in, 8'h10);
      chk("stall_ipc", bus.instr_pc, 8'h10);
      chk("stall_idata", bus.instr_data, mem_word(8'h10));
      chk("stall_load", {bus.pc_load, bus.pc_din}, {1'b1, 8'h10});
    end

    // Call 40 from 10, then return
    br_base = br_cnt;
    do_br(2'b10, 8'h40);
    wait_valid_pc(8'h40, 20, "call_to_40");
    do_br(2'b11, 8'h00);
`ifdef D8_FETCH_CALL_STACK_EN
    wait_valid_pc(8'h14, 20, "return_to_14");
    chk("return_no_err", bus.err, 0);
`else
    chk("ret_err_state", {bus.err, bus.busy, bus.instr_valid, bus.imem_req}, 4'b1000);
    pulse_start();
    step(3);
    chk("err_ignores_start", {bus.err, bus.busy, bus.imem_req}, 3'b100);
`endif
    chk("br_pulses", br_cnt - br_base, 2);

    // Relative F8 from 08 wraps to 00; sequential FC -> 00
    do_reset();
    bus.instr_ready = 1'b1;
    pulse_start();
    wait_valid_pc(8'h08, 40, "reach_08");
    bus.instr_ready = 1'b0;
    do_br(2'b01, 8'hF8);
    wait_valid_pc(8'h00, 20, "rel_wrap_00");
    do_br(2'b00, 8'hFC);
    wait_valid_pc(8'hFC, 20, "jump_fc");
    bus.instr_ready = 1'b1;
    step(1);
    bus.instr_ready = 1'b0;
    wait_valid_pc(8'h00, 20, "seq_wrap_00");
    chk("wrap_no_err", bus.err, 0);

`ifdef D8_FETCH_CALL_STACK_EN
    // Five nested calls, five returns on a 4-deep stack
    targets = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    rets    = '{8'h54, 8'h44, 8'h34, 8'h24};
    for (int i = 0; i < 5; i++) begin
      do_br(2'b10, targets[i]);
      wait_valid_pc(targets[i], 20, $sformatf("nest_call%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      do_br(2'b11, 8'h00);
      wait_valid_pc(rets[i], 20, $sformatf("nest_ret%0d", i));
    end
    do_br(2'b11, 8'h00);
    chk("underflow_err", {bus.err, bus.busy}, 2'b10);
`else
    targets = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    rets    = '{8'h00, 8'h00, 8'h00, 8'h00};
    // Without the stack a call is a plain jump
    do_br(2'b10, targets[0]);
    wait_valid_pc(targets[0], 20, "call_as_jump");
    chk("call_as_jump_err", bus.err, rets[0][0]);
`endif

    // Halt during FETCH, then resume at PC+4
    do_reset();
    pulse_start();
    wait_req(20, "halt_fetch_req");
    bus.halt = 1'b1;
    bus.instr_ready = 1'b1;
    base = issued.size();
    wait_idle(20, "halt_reached");
    bus.instr_ready = 1'b0;
    bus.halt = 1'b0;
    chk("halted_outputs", {bus.instr_valid, bus.imem_req, bus.pc_load, bus.pc_din, bus.pc_in},
        {1'b0, 1'b0, 1'b1, 8'h00, 8'h00});
    step(3);
    chk("halted_hold", {bus.busy, bus.pc_in}, {1'b0, 8'h00});
    chk("halt_consumed", issued.size() - base, 1);
    pulse_start();
    wait_valid_pc(8'h04, 20, "resume_at_04");

    // Reset during FETCH drops req at once; late ack is ignored
    bus.instr_ready = 1'b1;
    wait_req(20, "fetch08_req");
    bus.instr_ready = 1'b0;
    chk("fetch08_addr", bus.imem_addr, 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {bus.imem_req, bus.busy, bus.instr_valid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    inject_ack = 1'b1;
    step(1);
    inject_ack = 1'b0;
    step(3);
    chk("late_ack_ignored", {bus.busy, bus.instr_valid, bus.imem_req, bus.err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
